// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions,
// the hex-digit segment patterns and the scan-state encoding.
package seg7_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Places an a..g active-high glyph (a in the MSB) at the cathode bit positions.
    function automatic logic [7:0] seg_bits(input logic [6:0] abcdefg);
        logic [7:0] s;
        s         = '0;
        s[SEG_A]  = abcdefg[6];
        s[SEG_B]  = abcdefg[5];
        s[SEG_C]  = abcdefg[4];
        s[SEG_D]  = abcdefg[3];
        s[SEG_E]  = abcdefg[2];
        s[SEG_F]  = abcdefg[1];
        s[SEG_G]  = abcdefg[0];
        return s;
    endfunction

    localparam logic [7:0] SEG_PATTERN [16] = '{
        seg_bits(7'b1111110),  // 0
        seg_bits(7'b0110000),  // 1
        seg_bits(7'b1101101),  // 2
        seg_bits(7'b1111001),  // 3
        seg_bits(7'b0110011),  // 4
        seg_bits(7'b1011011),  // 5
        seg_bits(7'b1011111),  // 6
        seg_bits(7'b1110000),  // 7
        seg_bits(7'b1111111),  // 8
        seg_bits(7'b1111011),  // 9
        seg_bits(7'b1110111),  // A
        seg_bits(7'b0011111),  // b
        seg_bits(7'b1001110),  // C
        seg_bits(7'b0111101),  // d
        seg_bits(7'b1001111),  // E
        seg_bits(7'b1000111)   // F
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-cathode decoder; an invisible digit drives every
// cathode high, decimal point included.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       visible,
    input  logic       dp,
    output logic [7:0] cathodes
);

    logic [7:0] segs;

    always_comb begin
        segs         = SEG_PATTERN[nibble];
        segs[SEG_DP] = dp;
        cathodes     = visible ? ~segs : 8'hFF;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with shadowed display data,
// per-slot blank gap and optional leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [7:0]              cathodes,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam scan_state_e RESET_STATE = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    logic [4*NUM_DIGITS-1:0] value_sh;
    logic [NUM_DIGITS-1:0]   en_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic                    blank_lz_sh;

    logic [4*NUM_DIGITS-1:0] value_nx;
    logic [NUM_DIGITS-1:0]   en_nx;
    logic [NUM_DIGITS-1:0]   dp_nx;
    logic                    blank_lz_nx;

    logic [SLOT_W-1:0] slot_cnt;
    logic [SLOT_W-1:0] slot_nx;
    logic              slot_wrap;
    logic [IDX_W-1:0]  digit_idx;
    logic [IDX_W-1:0]  idx_nx;
    scan_state_e       state;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] visible_nx;
    logic                  seen_nz;
    logic [3:0]            sel_nibble;
    logic                  sel_visible;
    logic                  sel_dp;
    logic [7:0]            seg_nx;
    logic [7:0]            seg_slot;
    logic [NUM_DIGITS-1:0] anode_sel;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            value_sh    <= '0;
            en_sh       <= '0;
            dp_sh       <= '0;
            blank_lz_sh <= 1'b0;
        end else if (load) begin
            value_sh    <= value;
            en_sh       <= digit_en;
            dp_sh       <= dp;
            blank_lz_sh <= blank_lz;
        end
    end

    // Shadow contents as they will be after this edge, so a load coinciding
    // with a slot boundary is already seen by the slot that starts there.
    assign value_nx    = load ? value    : value_sh;
    assign en_nx       = load ? digit_en : en_sh;
    assign dp_nx       = load ? dp       : dp_sh;
    assign blank_lz_nx = load ? blank_lz : blank_lz_sh;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign slot_nx   = slot_wrap ? '0 : slot_cnt + 1'b1;

    always_comb begin
        idx_nx = digit_idx;
        if (slot_wrap) begin
            idx_nx = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end
    end

    // Walk from the top digit down; disabled digits never end the zero run.
    always_comb begin
        seen_nz = 1'b0;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (en_nx[i] && (value_nx[4*i +: 4] != 4'h0)) begin
                seen_nz = 1'b1;
            end
            lz_mask[i] = blank_lz_nx && !seen_nz && (i != 0);
        end
    end

    assign visible_nx = en_nx & ~lz_mask;

    always_comb begin
        sel_nibble  = 4'h0;
        sel_visible = 1'b0;
        sel_dp      = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nx == IDX_W'(i)) begin
                sel_nibble  = value_nx[4*i +: 4];
                sel_visible = visible_nx[i];
                sel_dp      = dp_nx[i];
            end
        end
    end

    seg7_decode u_decode (
        .nibble   (sel_nibble),
        .visible  (sel_visible),
        .dp       (sel_dp),
        .cathodes (seg_nx)
    );

    always_comb begin
        anode_sel = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                anode_sel[i] = 1'b0;
            end
        end
    end

    // Scan FSM. The digit pattern is frozen at each slot boundary so that a
    // mid-slot load only shows up from the following slot.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            state      <= RESET_STATE;
            seg_slot   <= 8'hFF;
            cathodes   <= 8'hFF;
            anodes     <= '1;
            frame_done <= 1'b0;
        end else begin
            slot_cnt   <= slot_nx;
            digit_idx  <= idx_nx;
            frame_done <= slot_wrap && (digit_idx == IDX_LAST);
            if (slot_wrap) begin
                seg_slot <= seg_nx;
            end

            case (state)
                ST_SHOW: begin
                    cathodes <= seg_slot;
                    anodes   <= anode_sel;
                end
                default: begin
                    cathodes <= 8'hFF;
                    anodes   <= '1;
                end
            endcase

            if (slot_nx == BLANK_END) begin
                state <= ST_SHOW;
            end else if (slot_nx == '0) begin
                state <= ST_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle gap).
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rstN;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
    logic        blank_lz;
    logic        load;
    logic [7:0]  cathodes;
    logic [3:0]  anodes;
    logic        frame_done;

    logic [12:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    logic [15:0] cur_v;
    logic [3:0]  cur_e;
    logic [3:0]  cur_d;
    logic        cur_lz;

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .value      (value),
        .digit_en   (digit_en),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .load       (load),
        .cathodes   (cathodes),
        .anodes     (anodes),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [7:0] model_seg(input logic [15:0] v, input logic [3:0] en,
                                             input logic [3:0] dpv, input logic lz, input int d);
        logic [3:0] nib;
        logic [6:0] g;
        logic       nz_at_or_above;
        logic       vis;
        nib = v[4*d +: 4];
        nz_at_or_above = 1'b0;
        for (int j = d; j < ND; j++) begin
            if (en[j] && (v[4*j +: 4] != 4'h0)) nz_at_or_above = 1'b1;
        end
        vis = en[d] && !(lz && (d != 0) && !nz_at_or_above);
        case (nib)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        if (!vis) return 8'hFF;
        return ~{g, dpv[d]};
    endfunction

    // Expected 32 output cycles following a frame_done cycle (or a reset release);
    // digits below sw use the old data, the rest the new data.
    task automatic push_frame(input logic [15:0] ov, input logic [3:0] oe, input logic [3:0] od,
                              input logic olz, input logic [15:0] nv, input logic [3:0] ne,
                              input logic [3:0] nd, input logic nlz, input int sw);
        logic [3:0] an;
        logic [7:0] cs;
        int d;
        for (int k = 1; k <= FRAME; k++) begin
            d = (k - 1) / RD;
            if (((k - 1) % RD) < BC) begin
                an = 4'hF;
                cs = 8'hFF;
            end else begin
                an = 4'hF;
                an[d] = 1'b0;
                cs = (d < sw) ? model_seg(ov, oe, od, olz, d) : model_seg(nv, ne, nd, nlz, d);
            end
            exp_q.push_back({(k == FRAME), an, cs});
        end
    endtask

    task automatic check_frame(input string name, input int load_k, input logic [15:0] lv,
                               input logic [3:0] le, input logic [3:0] ld, input logic llz,
                               input bit jitter);
        logic [12:0] got;
        logic [12:0] want;
        for (int k = 1; k <= FRAME; k++) begin
            tick();
            got  = {frame_done, anodes, cathodes};
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL %s k=%0d: got fd=%b an=%b cath=%h, want fd=%b an=%b cath=%h",
                         name, k, got[12], got[11:8], got[7:0], want[12], want[11:8], want[7:0]);
            end
            if (jitter) value = 16'($urandom);
            if (k == load_k) begin
                value = lv; digit_en = le; dp = ld; blank_lz = llz; load = 1'b1;
                cur_v = lv; cur_e = le; cur_d = ld; cur_lz = llz;
            end else if (k == load_k + 1) begin
                load = 1'b0;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d,
                           input logic lz);
        value = v; digit_en = e; dp = d; blank_lz = lz; load = 1'b1;
        tick();
        load = 1'b0;
        cur_v = v; cur_e = e; cur_d = d; cur_lz = lz;
    endtask

    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            tick();
            if (frame_done === 1'b1) seen = 1'b1;
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, 3 * FRAME);
        end
    endtask

    task automatic check_idle(input string name);
        compared++;
        if ({frame_done, anodes, cathodes} !== {1'b0, 4'hF, 8'hFF}) begin
            mismatched++;
            $display("FAIL %s: got fd=%b an=%b cath=%h, want fd=0 an=1111 cath=ff",
                     name, frame_done, anodes, cathodes);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; load = 1'b1;
        value = 16'hBEEF; digit_en = 4'hF; dp = 4'hF; blank_lz = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("reset_hold");
            value = 16'($urandom);
        end
        rstN = 1'b1; load = 1'b0;
        cur_v = '0; cur_e = '0; cur_d = '0; cur_lz = 1'b0;
        push_frame(cur_v, cur_e, cur_d, cur_lz, cur_v, cur_e, cur_d, cur_lz, 0);
        check_frame("reset_release", -1, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_basic_scan();
        do_load(16'h1A50, 4'hF, 4'b0010, 1'b0);
        wait_frame("basic_sync");
        for (int f = 0; f < 2; f++) begin
            push_frame(cur_v, cur_e, cur_d, cur_lz, cur_v, cur_e, cur_d, cur_lz, 0);
            check_frame("basic_scan", -1, '0, '0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_leading_zero();
        do_load(16'h0050, 4'hF, 4'h0, 1'b1);
        wait_frame("lz_sync");
        push_frame(cur_v, cur_e, cur_d, cur_lz, cur_v, cur_e, cur_d, cur_lz, 0);
        check_frame("lz_0050", -1, '0, '0, '0, 1'b0, 1'b0);
        do_load(16'h0000, 4'hF, 4'h0, 1'b1);
        wait_frame("lz_sync");
        push_frame(cur_v, cur_e, cur_d, cur_lz, cur_v, cur_e, cur_d, cur_lz, 0);
        check_frame("lz_0000", -1, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_disabled_in_run();
        do_load(16'h0003, 4'b1011, 4'h0, 1'b1);
        wait_frame("dis_sync");
        push_frame(cur_v, cur_e, cur_d, cur_lz, cur_v, cur_e, cur_d, cur_lz, 0);
        check_frame("disabled_in_run", -1, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_coherent_load();
        do_load(16'h2468, 4'hF, 4'b0101, 1'b0);
        wait_frame("coh_sync");
        push_frame(cur_v, cur_e, cur_d, cur_lz, cur_v, cur_e, cur_d, cur_lz, 0);
        check_frame("coherent_hold", -1, '0, '0, '0, 1'b0, 1'b1);
        // load sampled in digit 1's slot: digits 2 and 3 pick it up
        push_frame(cur_v, cur_e, cur_d, cur_lz, 16'h9C3E, 4'hF, 4'b1000, 1'b0, 2);
        check_frame("coherent_midload", 12, 16'h9C3E, 4'hF, 4'b1000, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        // load sampled in the last cycle of digit 0's slot: digit 1 onward is new
        push_frame(cur_v, cur_e, cur_d, cur_lz, 16'h7E01, 4'b1101, 4'b0001, 1'b1, 1);
        check_frame("slot_edge_load", RD - 1, 16'h7E01, 4'b1101, 4'b0001, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_load(16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
            wait_frame("rand_sync");
            push_frame(cur_v, cur_e, cur_d, cur_lz, cur_v, cur_e, cur_d, cur_lz, 0);
            check_frame("random", -1, '0, '0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_midscan_reset();
        do_load(16'h4321, 4'hF, 4'hF, 1'b0);
        wait_frame("mid_sync");
        for (int k = 1; k <= 20; k++) tick();
        compared++;
        if (anodes !== 4'b1011) begin
            mismatched++;
            $display("FAIL midscan_pre: got an=%b, want an=1011", anodes);
        end
        rstN = 1'b0;
        tick();
        check_idle("midscan_reset");
        rstN = 1'b1;
        cur_v = '0; cur_e = '0; cur_d = '0; cur_lz = 1'b0;
        push_frame(cur_v, cur_e, cur_d, cur_lz, cur_v, cur_e, cur_d, cur_lz, 0);
        check_frame("post_reset", -1, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_leading_zero();
        test_disabled_in_run();
        test_coherent_load();
        test_back_to_back();
        test_random();
        test_midscan_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
